// File: rtl/hex_ctrl_pkg.sv
// hex_ctrl_pkg: shared definitions for the six-digit hex display controller.
//   - Avalon-MM register addresses
//   - CTRL mode encodings
//   - display source FSM state enum
//   - 16-entry seven-segment font (active-low, bit0..6 = a..g)
package hex_ctrl_pkg;

  localparam logic [1:0] ADDR_SW_DIGITS = 2'd0;
  localparam logic [1:0] ADDR_CTRL      = 2'd1;
  localparam logic [1:0] ADDR_BLINK_DIV = 2'd2;
  localparam logic [1:0] ADDR_STATUS    = 2'd3;

  // Mode 3 is not named; it falls into the SW branch wherever modes are decoded.
  localparam logic [1:0] MODE_SW   = 2'd0;
  localparam logic [1:0] MODE_HW   = 2'd1;
  localparam logic [1:0] MODE_AUTO = 2'd2;

  typedef enum logic [1:0] {
    S_SW       = 2'd0,
    S_HW_FIXED = 2'd1,
    S_HW_HOLD  = 2'd2
  } src_state_e;

  // BLINK_DIV is a 24-bit field on the bus, but its reset value (25_000_000)
  // needs bit 24, so the stored register is one bit wider.
  localparam int BLINK_W = 25;

  // Active-low segments {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: combinational decoder for one seven-segment display.
// Ports:
//   digit_i  4-bit hex value to show
//   blank_i  1 = all of segments a..g off (dp unaffected)
//   dp_i     1 = decimal point lit
//   seg_o    active-low segments, bit0..6 = a..g, bit7 = dp
module hex_seg_decode
  import hex_ctrl_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o      = 8'hFF;
    seg_o[7]   = ~dp_i;
    seg_o[6:0] = blank_i ? 7'h7F : SEG_FONT[digit_i];
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: Avalon-MM slave driving six seven-segment displays,
// shared between software digits and a hardware score source.
// Optional feature macro: HEX_CTRL_BLINK_EN (blink divider, BLINK_DIV register,
// CTRL blink mask, STATUS blink phase). Without it those read as 0.
// Ports:
//   clk, reset_n         clock; asynchronous active-low reset
//   address/chipselect/write_n/writedata/readdata
//                        Avalon-MM slave, zero wait states, combinational read
//   hw_digits/hw_valid   six hex digits from game logic, one-cycle latch strobe
//   hex_out              registered active-low segments, display k at [8k+7:8k]
//   src_state_o          current source FSM state (debug)
// Handshake: there is no ready/backpressure. A bus write is accepted on every
// clock edge where chipselect && !write_n; hw_valid is a one-cycle strobe that
// is always accepted on the edge where it is high. Reads have no side effects.
module hex_display_ctrl
  import hex_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 100_000_000,
  parameter int unsigned BLINK_DIV_RST = 25_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [23:0] hw_digits,
  input  logic        hw_valid,
  output logic [47:0] hex_out,
  output src_state_e  src_state_o
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic wr_en, sw_wr, ctrl_wr, div_wr;
  assign wr_en   = chipselect & ~write_n;
  assign sw_wr   = wr_en && (address == ADDR_SW_DIGITS);
  assign ctrl_wr = wr_en && (address == ADDR_CTRL);
  assign div_wr  = wr_en && (address == ADDR_BLINK_DIV);

  logic [23:0]       sw_digits_q;
  logic [23:0]       hw_latch_q;
  logic [1:0]        mode_q;
  logic [5:0]        blank_q;
  logic [5:0]        dp_q;
  src_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [47:0]       hex_q;

  logic [5:0]         blink_mask_w;
  logic               phase_w;
  logic [BLINK_W-1:0] div_rd_w;

  // ---------------------------------------------------------------------------
  // Blink divider (optional)
  // ---------------------------------------------------------------------------
`ifdef HEX_CTRL_BLINK_EN
  logic [5:0]         blink_mask_q;
  logic [BLINK_W-1:0] div_q;
  logic [BLINK_W-1:0] bcnt_q;
  logic               phase_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask_q <= '0;
      div_q        <= BLINK_W'(BLINK_DIV_RST);
      bcnt_q       <= '0;
      phase_q      <= 1'b0;
    end else begin
      if (ctrl_wr) blink_mask_q <= writedata[19:14];
      if (div_wr) begin
        // A zero divisor would never toggle; store it as 1 instead.
        div_q   <= (writedata[23:0] == 24'd0) ? BLINK_W'(1) : {1'b0, writedata[23:0]};
        bcnt_q  <= '0;
        phase_q <= 1'b0;
      end else if (bcnt_q >= div_q - 1'b1) begin
        bcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        bcnt_q  <= bcnt_q + 1'b1;
      end
    end
  end

  assign blink_mask_w = blink_mask_q;
  assign phase_w      = phase_q;
  assign div_rd_w     = div_q;

  logic unused_wd;
  assign unused_wd = ^writedata[31:24];
`else
  assign blink_mask_w = '0;
  assign phase_w      = 1'b0;
  assign div_rd_w     = '0;

  logic unused_wd;
  assign unused_wd = ^{writedata[31:24], writedata[19:14], BLINK_DIV_RST};
`endif

  // ---------------------------------------------------------------------------
  // Source FSM: the mode seen this cycle is the one being written, if any,
  // so a CTRL write steers the very next state.
  // ---------------------------------------------------------------------------
  logic [1:0] mode_n;
  logic       entering_auto;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    mode_n        = ctrl_wr ? writedata[1:0] : mode_q;
    entering_auto = ctrl_wr && (mode_q != MODE_AUTO);
    case (mode_n)
      MODE_HW: begin
        state_d = S_HW_FIXED;
        hold_d  = '0;
      end
      MODE_AUTO: begin
        if (hw_valid) begin
          state_d = S_HW_HOLD;
          hold_d  = HOLD_LOAD;
        end else if (entering_auto || (state_q != S_HW_HOLD)) begin
          state_d = S_SW;
          hold_d  = '0;
        end else if (hold_q == '0) begin
          state_d = S_SW;
        end else begin
          hold_d  = hold_q - 1'b1;
        end
      end
      default: begin
        state_d = S_SW;
        hold_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Digit selection and decode
  // ---------------------------------------------------------------------------
  logic [23:0] disp_digits;
  logic [47:0] seg_d;

  assign disp_digits = (state_q == S_SW) ? sw_digits_q : hw_latch_q;

  for (genvar k = 0; k < 6; k++) begin : g_digit
    hex_seg_decode u_dec (
      .digit_i (disp_digits[4*k +: 4]),
      .blank_i (blank_q[k] | (blink_mask_w[k] & phase_w)),
      .dp_i    (dp_q[k]),
      .seg_o   (seg_d[8*k +: 8])
    );
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_digits_q <= '0;
      hw_latch_q  <= '0;
      mode_q      <= MODE_SW;
      blank_q     <= '0;
      dp_q        <= '0;
      state_q     <= S_SW;
      hold_q      <= '0;
      hex_q       <= '1;
    end else begin
      if (sw_wr) sw_digits_q <= writedata[23:0];
      if (ctrl_wr) begin
        mode_q  <= writedata[1:0];
        blank_q <= writedata[7:2];
        dp_q    <= writedata[13:8];
      end
      if (hw_valid) hw_latch_q <= hw_digits;
      state_q <= state_d;
      hold_q  <= hold_d;
      hex_q   <= seg_d;
    end
  end

  assign hex_out     = hex_q;
  assign src_state_o = state_q;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_SW_DIGITS: readdata = {8'd0, sw_digits_q};
      ADDR_CTRL:      readdata = {12'd0, blink_mask_w, dp_q, blank_q, mode_q};
      ADDR_BLINK_DIV: readdata = {{(32-BLINK_W){1'b0}}, div_rd_w};
      ADDR_STATUS:    readdata = {29'd0, (hold_q != '0), phase_w, (state_q != S_SW)};
      default:        readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;
  import hex_ctrl_pkg::*;

`ifdef HEX_CTRL_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [23:0] hw_digits;
  logic        hw_valid;
  logic [47:0] hex_out;
  src_state_e  src_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hex_display_ctrl #(
    .HOLD_CYCLES   (10),
    .BLINK_DIV_RST (25_000_000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .hw_digits   (hw_digits),
    .hw_valid    (hw_valid),
    .hex_out     (hex_out),
    .src_state_o (src_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent seven-segment reference (dp off).
  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [47:0] disp(input logic [23:0] dg);
    logic [47:0] r;
    r = '0;
    for (int k = 0; k < 6; k++) r[8*k +: 8] = seg7(dg[4*k +: 4]);
    return r;
  endfunction

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d,
                           input logic with_hw, input logic [23:0] hd);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    hw_valid   = with_hw;
    hw_digits  = hd;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    hw_valid   = 1'b0;
  endtask

  task automatic pulse_hw(input logic [23:0] hd);
    hw_digits = hd;
    hw_valid  = 1'b1;
    @(negedge clk);
    hw_valid  = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic [47:0] exp_v;
  logic [23:0] vals [6];

  initial begin
    vals = '{24'hABCDEF, 24'h987654, 24'h000000, 24'h13579B, 24'hFFFFFF, 24'h2468AC};
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; hw_digits = '0; hw_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_hex", hex_out, 48'hFFFF_FFFF_FFFF);
    reset_n = 1'b1;
    bus_read(ADDR_SW_DIGITS, rd); check("reset_sw", rd, 32'd0);
    bus_read(ADDR_CTRL, rd);      check("reset_ctrl", rd, 32'd0);
    bus_read(ADDR_BLINK_DIV, rd); check("reset_div", rd, BLINK_ON ? 32'd25_000_000 : 32'd0);
    bus_read(ADDR_STATUS, rd);    check("reset_status", rd, 32'd0);
    @(negedge clk);

    // SW digits, one-cycle output latency
    bus_write(ADDR_SW_DIGITS, 32'h0001_2345, 1'b0, '0);
    check("sw_latency", hex_out, 48'hC0C0_C0C0_C0C0);
    @(negedge clk);
    check("sw_digits", hex_out, 48'hC0F9_A4B0_9992);
    check("sw_disp0", hex_out[7:0], 8'h92);
    bus_read(ADDR_SW_DIGITS, rd); check("sw_readback", rd, 32'h0001_2345);
    @(negedge clk);

    // hw_valid latches in SW mode without changing the source
    pulse_hw(24'hABCDEF);
    @(negedge clk);
    check("sw_ignores_hw", hex_out, disp(24'h012345));
    bus_write(ADDR_CTRL, 32'd1, 1'b0, '0);
    @(negedge clk);
    check("hw_fixed", hex_out, 48'h8883_C6A1_868E);
    check("hw_fixed_state", src_state, S_HW_FIXED);
    bus_read(ADDR_STATUS, rd); check("hw_fixed_status", rd, 32'd1);
    bus_read(ADDR_CTRL, rd);   check("ctrl_readback", rd, 32'd1);
    @(negedge clk);
    bus_write(ADDR_CTRL, 32'd3, 1'b0, '0);
    @(negedge clk);
    check("mode3_is_sw", hex_out, disp(24'h012345));
    bus_read(ADDR_STATUS, rd); check("mode3_status", rd, 32'd0);
    @(negedge clk);

    // Blank digit 1, dp on digits 0 and 1
    bus_write(ADDR_CTRL, 32'h0000_0308, 1'b0, '0);
    @(negedge clk);
    check("blank_dp", hex_out, 48'hC0F9_A4B0_7F12);
    bus_read(ADDR_CTRL, rd); check("blank_dp_ctrl", rd, 32'h0000_0308);
    @(negedge clk);

    // AUTO: one hw_valid holds HW for 10 cycles
    bus_write(ADDR_CTRL, 32'd2, 1'b0, '0);
    bus_read(ADDR_STATUS, rd); check("auto_entry_status", rd, 32'd0);
    @(negedge clk);
    pulse_hw(24'hABCDEF);
    for (int k = 0; k <= 12; k++)
      exp_q.push_back((k >= 1 && k <= 10) ? disp(24'hABCDEF) : disp(24'h012345));
    for (int k = 0; k <= 12; k++) begin
      exp_v = exp_q.pop_front();
      check($sformatf("hold_k%0d", k), hex_out, exp_v);
      if (k == 1 || k >= 10) begin
        bus_read(ADDR_STATUS, rd);
        check($sformatf("hold_busy_k%0d", k), {47'd0, rd[2]}, {47'd0, (k == 1)});
      end
      @(negedge clk);
    end

    // hw_valid every 5 cycles keeps HW on screen
    for (int i = 0; i < 6; i++) begin
      pulse_hw(vals[i]);
      check($sformatf("rep_prev%0d", i), hex_out, (i == 0) ? disp(24'h012345) : disp(vals[i-1]));
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        check($sformatf("rep%0d_%0d", i, j), hex_out, disp(vals[i]));
      end
    end

    // Simultaneous hw_valid and SW_DIGITS write in AUTO
    bus_write(ADDR_CTRL, 32'd0, 1'b0, '0);
    bus_write(ADDR_CTRL, 32'd2, 1'b0, '0);
    bus_write(ADDR_SW_DIGITS, 32'h0011_1111, 1'b1, 24'h222222);
    @(negedge clk);
    check("sim_sw_hw_disp", hex_out, disp(24'h222222));
    bus_read(ADDR_SW_DIGITS, rd); check("sim_sw_hw_reg", rd, 32'h0011_1111);
    repeat (12) @(negedge clk);
    check("sim_sw_hw_expire", hex_out, disp(24'h111111));

    // Simultaneous hw_valid and CTRL write to AUTO
    bus_write(ADDR_CTRL, 32'd0, 1'b0, '0);
    bus_write(ADDR_CTRL, 32'd2, 1'b1, 24'h333333);
    @(negedge clk);
    check("sim_ctrl_hw_disp", hex_out, disp(24'h333333));
    check("sim_ctrl_hw_state", src_state, S_HW_HOLD);
    bus_read(ADDR_STATUS, rd); check("sim_ctrl_hw_status", rd, 32'd5);
    @(negedge clk);

    // Reset mid-hold
    pulse_hw(24'h444444);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_hold_hex", hex_out, 48'hFFFF_FFFF_FFFF);
    check("rst_hold_state", src_state, S_SW);
    bus_read(ADDR_STATUS, rd);    check("rst_hold_status", rd, 32'd0);
    bus_read(ADDR_SW_DIGITS, rd); check("rst_hold_sw", rd, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Blink digit 0 with BLINK_DIV=4, dp lit on digit 0
    bus_write(ADDR_SW_DIGITS, 32'h0001_2345, 1'b0, '0);
    bus_write(ADDR_CTRL, 32'h0000_4100, 1'b0, '0);
    bus_read(ADDR_CTRL, rd); check("blink_ctrl", rd, BLINK_ON ? 32'h0000_4100 : 32'h0000_0100);
    @(negedge clk);
    bus_write(ADDR_BLINK_DIV, 32'd4, 1'b0, '0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("blink_k%0d", k), hex_out[7:0],
            (BLINK_ON && (((k - 1) / 4) % 2 == 1)) ? 8'h7F : 8'h12);
      bus_read(ADDR_STATUS, rd);
      check($sformatf("phase_k%0d", k), {47'd0, rd[1]}, {47'd0, (BLINK_ON && ((k / 4) % 2 == 1))});
    end
    @(negedge clk);
    bus_write(ADDR_BLINK_DIV, 32'd0, 1'b0, '0);
    bus_read(ADDR_BLINK_DIV, rd); check("div_zero", rd, BLINK_ON ? 32'd1 : 32'd0);
    @(negedge clk);

    // Reset mid-blink
    bus_write(ADDR_BLINK_DIV, 32'd4, 1'b0, '0);
    repeat (5) @(negedge clk);
    bus_read(ADDR_STATUS, rd); check("pre_rst_phase", {47'd0, rd[1]}, {47'd0, BLINK_ON});
    reset_n = 1'b0;
    #1;
    bus_read(ADDR_STATUS, rd);    check("rst_blink_status", rd, 32'd0);
    bus_read(ADDR_BLINK_DIV, rd); check("rst_blink_div", rd, BLINK_ON ? 32'd25_000_000 : 32'd0);
    check("rst_blink_hex", hex_out, 48'hFFFF_FFFF_FFFF);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
